// File: rtl/crc16_pkg.sv
// crc16_pkg -- shared constants and types for the CRC-16 (0x8005) datapath.
//
// Contents:
//   CRC16_W     remainder width (16)
//   CRC16_POLY  generator x^16+x^15+x^2+1, implicit x^16 term dropped
//   CRC16_INIT  remainder value at the start of every frame
//   crc16_state_t  frame-checker FSM states
package crc16_pkg;

  localparam int                 CRC16_W    = 16;
  localparam logic [CRC16_W-1:0] CRC16_POLY = 16'h8005;
  localparam logic [CRC16_W-1:0] CRC16_INIT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2
  } crc16_state_t;

endpackage

// File: rtl/crc16_lfsr_step.sv
// crc16_lfsr_step -- one serial step of the non-reflected CRC-16 register.
// Purely combinational so it can be shared by the checker and a transmit
// encoder.
//
// Ports:
//   r       current remainder
//   din     incoming serial bit
//   r_next  remainder after absorbing din
module crc16_lfsr_step
  import crc16_pkg::*;
(
  input  logic [CRC16_W-1:0] r,
  input  logic               din,
  output logic [CRC16_W-1:0] r_next
);

  logic fb;

  // Shift left and fold the generator back in when the feedback bit is set;
  // with 0x8005 this drives taps 0, 2 and 15.
  assign fb     = r[CRC16_W-1] ^ din;
  assign r_next = {r[CRC16_W-2:0], 1'b0} ^ ({CRC16_W{fb}} & CRC16_POLY);

endmodule

// File: rtl/crc16_check.sv
// crc16_check -- serial CRC-16 frame checker.
// A frame is DATA_BITS payload bits (MSB first) followed by 16 CRC bits
// (MSB first). Payload bits are passed through registered; after the last
// CRC bit a one-cycle frame_done pulse reports the verdict and the final
// remainder.
//
// Parameters:
//   DATA_BITS   payload bits per frame (1..4096)
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-low
//   din         serial frame bit, qualified by din_valid
//   din_valid   din accepted this cycle
//   sof         accepted bit is the first bit of a frame
//   dout        registered payload bit
//   dout_valid  dout carries a payload bit accepted last cycle
//   frame_done  one-cycle pulse after the last CRC bit
//   crc_ok      remainder was zero (valid with frame_done)
//   crc_err     remainder was non-zero (valid with frame_done)
//   crc_rem     final remainder, held until the next frame_done
//   err_count   saturating count of crc_err pulses
//               (only when CRC16_CHK_ERRCNT_EN is defined)
//
// State | meaning
// IDLE  | waiting for an accepted sof; other accepted bits are dropped
// DATA  | absorbing payload bits and passing them to dout
// CRC   | absorbing the 16 CRC bits; verdict on the last one
module crc16_check
  import crc16_pkg::*;
#(
  parameter int DATA_BITS = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               sof,
  output logic               dout,
  output logic               dout_valid,
  output logic               frame_done,
  output logic               crc_ok,
  output logic               crc_err,
  output logic [CRC16_W-1:0] crc_rem
`ifdef CRC16_CHK_ERRCNT_EN
  ,
  output logic [15:0]        err_count
`endif
);

  localparam int CNT_W = $clog2(DATA_BITS + CRC16_W);
  // Down-counter holds the bits still to come after the current one.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_BITS + CRC16_W - 1);
  localparam logic [CNT_W-1:0] CNT_CRC  = CNT_W'(CRC16_W);

  crc16_state_t       state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_dec;
  logic [CRC16_W-1:0] crc_r;
  logic [CRC16_W-1:0] r_base;
  logic [CRC16_W-1:0] r_step;
  logic               start;

  // An accepted sof restarts from any state, so the register is seeded
  // from the init value in the same cycle the first bit is absorbed.
  assign start   = din_valid & sof;
  assign r_base  = start ? CRC16_INIT : crc_r;
  assign cnt_dec = cnt - 1'b1;

  crc16_lfsr_step u_step (
    .r      (r_base),
    .din    (din),
    .r_next (r_step)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      crc_r      <= CRC16_INIT;
      crc_rem    <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
`ifdef CRC16_CHK_ERRCNT_EN
      err_count  <= '0;
`endif
    end else begin
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
      if (start) begin
        crc_r      <= r_step;
        cnt        <= CNT_LOAD;
        dout       <= din;
        dout_valid <= 1'b1;
        // A one-bit payload is already complete after the sof bit.
        state      <= (CNT_LOAD == CNT_CRC) ? ST_CRC : ST_DATA;
      end else if (din_valid) begin
        case (state)
          ST_IDLE: begin
          end
          ST_DATA: begin
            crc_r      <= r_step;
            cnt        <= cnt_dec;
            dout       <= din;
            dout_valid <= 1'b1;
            if (cnt_dec == CNT_CRC) state <= ST_CRC;
          end
          ST_CRC: begin
            crc_r <= r_step;
            cnt   <= cnt_dec;
            if (cnt_dec == '0) begin
              state      <= ST_IDLE;
              frame_done <= 1'b1;
              crc_ok     <= (r_step == '0);
              crc_err    <= (r_step != '0);
              crc_rem    <= r_step;
`ifdef CRC16_CHK_ERRCNT_EN
              if ((r_step != '0) && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;
`endif
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
